// File: rtl/spi_csr_master.sv
// rtl/spi_csr_master.sv - SPI mode-0 peripheral bridge issuing CSR reads and writes
module spi_csr_master #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 8,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  busy_o
);
    localparam int CMD_W = 1 + ADDR_WIDTH;
    localparam int SH_W  = (CMD_W > DATA_WIDTH) ? CMD_W : DATA_WIDTH;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam int ACC_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, CMD, RD_ACCESS, RD_SHIFT, WR_DATA, WR_ACCESS, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sclk_sync_q, sclk_sync_d;
    logic [1:0]            cs_sync_q, cs_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;
    logic                  sclk_prev_q, sclk_prev_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [ACC_W-1:0]      acc_cnt_q, acc_cnt_d;
    logic [SH_W-2:0]       rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  write_en_q, write_en_d;
    logic                  read_en_q, read_en_d;
    logic                  busy_q, busy_d;

    logic            sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
    logic [SH_W-1:0] rx_shift;

    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign rx_shift  = {rx_q, mosi_s};

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[0], sclk_i};
        cs_sync_d    = {cs_sync_q[0], cs_n_i};
        mosi_sync_d  = {mosi_sync_q[0], mosi_i};
        sclk_prev_d  = sclk_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = 1'b0;
        miso_oe_d    = miso_oe_q;
        addr_d       = addr_q;
        write_data_d = write_data_q;
        write_en_d   = write_en_q;
        read_en_d    = read_en_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d   = CMD;
                    miso_oe_d = 1'b1;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end
            end
            CMD: begin
                if (cs_s) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_d = rx_shift[SH_W-2:0];
                    if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                        addr_d    = rx_shift[ADDR_WIDTH-1:0];
                        bit_cnt_d = '0;
                        acc_cnt_d = '0;
                        if (rx_shift[ADDR_WIDTH]) begin
                            state_d   = RD_ACCESS;
                            read_en_d = 1'b1;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            // A started access always runs its full strobe; cs_n is only honoured afterwards.
            RD_ACCESS: begin
                if (read_en_q) begin
                    if (acc_cnt_q == ACC_W'(ACCESS_CYCLES - 1)) begin
                        read_en_d = 1'b0;
                    end else begin
                        acc_cnt_d = acc_cnt_q + 1'b1;
                    end
                end else begin
                    tx_d   = read_data_i;
                    busy_d = 1'b0;
                    if (cs_s) begin
                        state_d   = IDLE;
                        miso_oe_d = 1'b0;
                    end else begin
                        state_d = RD_SHIFT;
                    end
                end
            end
            RD_SHIFT: begin
                miso_d = miso_q;
                if (cs_s) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                end else if (sclk_fall && bit_cnt_q != CNT_W'(DATA_WIDTH)) begin
                    miso_d    = tx_q[DATA_WIDTH-1];
                    tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (sclk_rise && bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
                    // Last bit stays on MISO until the host has sampled it.
                    state_d = DONE;
                    miso_d  = 1'b0;
                end
            end
            WR_DATA: begin
                if (cs_s) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_d = rx_shift[SH_W-2:0];
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        write_data_d = rx_shift[DATA_WIDTH-1:0];
                        write_en_d   = 1'b1;
                        acc_cnt_d    = '0;
                        state_d      = WR_ACCESS;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            WR_ACCESS: begin
                if (acc_cnt_q == ACC_W'(ACCESS_CYCLES - 1)) begin
                    write_en_d = 1'b0;
                    busy_d     = 1'b0;
                    if (cs_s) begin
                        state_d   = IDLE;
                        miso_oe_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (cs_s) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                miso_oe_d  = 1'b0;
                busy_d     = 1'b0;
                write_en_d = 1'b0;
                read_en_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            bit_cnt_q    <= '0;
            acc_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            addr_q       <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            addr_q       <= addr_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
            busy_q       <= busy_d;
        end
    end

    assign miso_o       = miso_q;
    assign miso_oe_o    = miso_oe_q;
    assign addr_o       = addr_q;
    assign write_data_o = write_data_q;
    assign write_en_o   = write_en_q;
    assign read_en_o    = read_en_q;
    assign busy_o       = busy_q;
endmodule
